// File: rtl/ram_pkg.sv
// Shared constants for the 2048x8 single-port RAM and the read master state encoding.
package ram_pkg;

    localparam int RAM_ADDR_W = 11;
    localparam int RAM_DATA_W = 8;
    localparam int MEM_DEPTH  = 2048;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO holding RAM read data until the stream sink takes it.
module ram_rd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    // Storage is cleared on reset so the head reads as zero after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read master: fetches a wrapping range of RAM bytes and streams them out in order,
// with read credits sized to the output FIFO so backpressure never drops data.
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W:0]   LENGTH,
    output logic              BUSY,
    output logic              DONE,
    output logic              EN,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic              WE,
    output logic [DATA_W-1:0] DI,
    input  logic [DATA_W-1:0] DO,
    output logic [DATA_W-1:0] O_DATA,
    output logic              O_VALID,
    input  logic              O_READY
);

    localparam int              CRED_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   issue_left_q, issue_left_d;
    logic [ADDR_W:0]   xfer_left_q, xfer_left_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              push_q;

    logic [ADDR_W:0]   len_clip;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              pop;
    logic [DATA_W-1:0] fifo_data;
    logic [CRED_W-1:0] fifo_count;

    assign len_clip = (LENGTH > MAX_LEN) ? MAX_LEN : LENGTH;
    assign O_VALID  = (fifo_count != '0);
    assign pop      = O_VALID & O_READY;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        xfer_left_d  = xfer_left_q;
        address_d    = address_q;
        busy_d       = busy_q;
        en_d         = 1'b0;
        done_d       = 1'b0;
        issue        = 1'b0;
        issue_addr   = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (len_clip == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First read goes out straight from the request so EN lands one cycle after START.
                        issue        = 1'b1;
                        issue_addr   = START_ADDR;
                        issue_left_d = len_clip;
                        xfer_left_d  = len_clip;
                        busy_d       = 1'b1;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue_left_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (credits_q != '0) begin
                    issue = 1'b1;
                end
            end
            default: ;
        endcase

        if (issue) begin
            en_d         = 1'b1;
            address_d    = issue_addr;
            addr_d       = issue_addr + 1'b1;
            issue_left_d = issue_left_d - 1'b1;
        end

        credits_d = credits_q - CRED_W'(issue) + CRED_W'(pop);

        if (pop) begin
            xfer_left_d = xfer_left_q - 1'b1;
            if (xfer_left_q == LEN_ONE) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            xfer_left_q  <= '0;
            credits_q    <= CRED_W'(FIFO_DEPTH);
            address_q    <= '0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            push_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            xfer_left_q  <= xfer_left_d;
            credits_q    <= credits_d;
            address_q    <= address_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            // DO is valid the cycle after EN, so push follows EN by one cycle.
            push_q       <= en_q;
        end
    end

    ram_rd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push_q),
        .data_i  (DO),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .count_o (fifo_count)
    );

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign EN      = en_q;
    assign ADDRESS = address_q;
    assign WE      = 1'b0;
    assign DI      = '0;
    assign O_DATA  = fifo_data;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed and randomized checks of ram_stream_reader against a queue-based model of the byte stream.
module tb_ram_stream_reader;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [AW-1:0] START_ADDR;
    logic [AW:0]   LENGTH;
    logic          BUSY, DONE, EN, WE;
    logic [AW-1:0] ADDRESS;
    logic [DW-1:0] DI, DO, O_DATA;
    logic          O_VALID, O_READY;

    int n_cmp = 0;
    int n_err = 0;

    int r_first, r_done, r_en, r_en_hold, r_bytes;
    bit r_busy_seen, r_busy_at_done, r_aborted;

    logic [7:0] ram [0:2047];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (EN && !WE) DO <= ram[ADDRESS];
    end

    ram_stream_reader dut (
        .CLK(CLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .LENGTH(LENGTH),
        .BUSY(BUSY), .DONE(DONE), .EN(EN), .ADDRESS(ADDRESS), .WE(WE), .DI(DI), .DO(DO),
        .O_DATA(O_DATA), .O_VALID(O_VALID), .O_READY(O_READY)
    );

    function automatic logic [7:0] model_byte(input int a);
        return 8'(255 - (a % 256));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_en"}, EN, 0);
        chk({tag, "_address"}, ADDRESS, 0);
        chk({tag, "_we"}, WE, 0);
        chk({tag, "_di"}, DI, 0);
        chk({tag, "_ovalid"}, O_VALID, 0);
        chk({tag, "_odata"}, O_DATA, 0);
    endtask

    task automatic idle_check(input int n, input string tag);
        bit bad;
        bad = 1'b0;
        repeat (n) begin
            @(negedge CLK);
            if (EN !== 1'b0 || O_VALID !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
        end
        chk(tag, bad, 0);
    endtask

    // Entered on a negedge; START is presented for the cycle in progress (cycle 0).
    // mode: 0 ready always, 1 random ready, 2 ready low through cycle 'hold'.
    task automatic xfer(input int sa, input int len, input int mode, input int hold,
                        input int poke_cyc, input int abort_byte);
        logic [7:0] q[$];
        logic [7:0] exp_b, prev_data;
        int         eff, bound;
        bit         we_bad, prev_stall;
        eff = (len > 2048) ? 2048 : len;
        for (int k = 0; k < eff; k++) q.push_back(model_byte((sa + k) % 2048));
        r_first = -1; r_done = -1; r_en = 0; r_en_hold = -1; r_bytes = 0;
        r_busy_seen = 0; r_busy_at_done = 0; r_aborted = 0;
        we_bad = 0; prev_stall = 0; prev_data = '0;
        bound = 8 * eff + 2 * hold + 40;
        START = 1'b1; START_ADDR = AW'(sa); LENGTH = (AW+1)'(len);
        O_READY = (mode == 2) ? 1'b0 : 1'b1;
        for (int cyc = 1; cyc <= bound; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) START = 1'b0;
            if (poke_cyc > 1 && cyc == poke_cyc) begin
                START = 1'b1; START_ADDR = AW'(sa + 100); LENGTH = 3;
            end
            if (poke_cyc > 1 && cyc == poke_cyc + 1) START = 1'b0;
            if (WE !== 1'b0 || DI !== 8'h00) we_bad = 1'b1;
            if (BUSY === 1'b1) r_busy_seen = 1'b1;
            if (DONE === 1'b1) begin
                r_done = cyc; r_busy_at_done = BUSY;
                break;
            end
            if (EN === 1'b1) begin
                chk("rd_addr", ADDRESS, (sa + r_en) % 2048);
                r_en++;
            end
            if (O_VALID === 1'b1 && r_first < 0) r_first = cyc;
            if (prev_stall) begin
                chk("hold_valid", O_VALID, 1);
                chk("hold_data", O_DATA, prev_data);
            end
            if (hold > 0 && cyc == hold) begin
                r_en_hold = r_en;
                chk("stall_valid", O_VALID, 1);
                if (q.size() > 0) chk("stall_head", O_DATA, q[0]);
            end
            case (mode)
                0:       O_READY = 1'b1;
                1:       O_READY = 1'($urandom_range(0, 1));
                default: O_READY = (cyc > hold) ? 1'b1 : 1'b0;
            endcase
            if (O_VALID === 1'b1 && O_READY) begin
                if (q.size() == 0) begin
                    chk("byte_within_len", r_bytes + 1, eff);
                end else begin
                    exp_b = q.pop_front();
                    chk("data", O_DATA, exp_b);
                end
                r_bytes++;
                if (abort_byte > 0 && r_bytes == abort_byte) begin
                    RST = 1'b1; r_aborted = 1'b1;
                    break;
                end
            end
            prev_stall = (O_VALID === 1'b1) && !O_READY;
            prev_data  = O_DATA;
        end
        if (!r_aborted) begin
            chk("done_seen", (r_done >= 0), 1);
            chk("bytes_left", q.size(), 0);
            chk("busy_at_done", r_busy_at_done, 0);
        end
        chk("we_di_zero", we_bad, 0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = model_byte(i);
        RST = 1'b1; START = 1'b0; START_ADDR = '0; LENGTH = '0; O_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset("por");
        RST = 1'b0;
        @(negedge CLK);

        // Basic 4-byte read, timing pinned to the documented latency
        xfer(0, 4, 0, 0, 0, 0);
        chk("t1_first_valid", r_first, 3);
        chk("t1_done_cycle", r_done, 7);
        chk("t1_en_count", r_en, 4);
        chk("t1_busy_seen", r_busy_seen, 1);

        // Wrap 2047->0, started in the DONE cycle of the previous transfer
        xfer(2046, 4, 0, 0, 0, 0);
        chk("t2_first_valid", r_first, 3);
        chk("t2_done_cycle", r_done, 7);
        chk("t2_en_count", r_en, 4);
        idle_check(3, "t2_idle");

        // Backpressure: credits cap outstanding reads at the FIFO depth
        xfer(0, 16, 2, 10, 0, 0);
        chk("t3_en_while_stalled", r_en_hold, 4);
        chk("t3_bytes", r_bytes, 16);

        // Zero length, then START while busy
        xfer(50, 0, 0, 0, 0, 0);
        chk("t4_done_cycle", r_done, 1);
        chk("t4_en_count", r_en, 0);
        chk("t4_busy_seen", r_busy_seen, 0);
        xfer(300, 8, 0, 0, 4, 0);
        chk("t4_poke_bytes", r_bytes, 8);
        chk("t4_poke_en", r_en, 8);
        idle_check(4, "t4_idle");

        // Reset mid-transfer
        xfer(10, 8, 0, 0, 0, 3);
        chk("t5_aborted", r_aborted, 1);
        @(negedge CLK);
        check_reset("t5_rst");
        RST = 1'b0;
        idle_check(4, "t5_no_done");
        xfer(700, 2, 0, 0, 0, 0);
        chk("t5_bytes", r_bytes, 2);
        chk("t5_done_cycle", r_done, 5);

        // Randomized short transfers
        for (int t = 0; t < 4; t++) begin
            int ra, rl;
            ra = int'($urandom_range(0, 2047));
            rl = int'($urandom_range(1, 40));
            xfer(ra, rl, 1, 0, 0, 0);
            chk("rand_bytes", r_bytes, rl);
        end

        // Length above 2048 clips to the full RAM
        xfer(2040, 3000, 0, 0, 0, 0);
        chk("clip_bytes", r_bytes, 2048);
        chk("clip_en", r_en, 2048);

        // Full sweep with random backpressure
        xfer(5, 2048, 1, 0, 0, 0);
        chk("t6_bytes", r_bytes, 2048);
        chk("t6_en", r_en, 2048);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
